// File: rtl/actor_tile_committer_if.sv
// Board RAM port shared by the committer (master) and the tile board RAM (slave).
interface actor_tile_committer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TILE_W = 4
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [TILE_W-1:0] ram_wdata;
  logic [TILE_W-1:0] ram_rdata;

  modport master (output ram_addr, ram_we, ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, ram_we, ram_wdata, output ram_rdata);
endinterface

// File: rtl/actor_tile_committer.sv
// Commits new actor positions into the tile board RAM: erases moved actors by
// restoring their saved under-tile, redraws them at their new tile, and flags
// PacMan/ghost collisions.
module actor_tile_committer #(
  parameter int unsigned NUM_ACTORS = 5,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned NUM_TILES  = 768,
  parameter int unsigned TILE_W     = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter logic [TILE_W-1:0]            BG_TILE   = '0,
  parameter logic [NUM_ACTORS*ADDR_W-1:0] INIT_LOCS = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [NUM_ACTORS*ADDR_W-1:0] next_loc,
  input  logic [NUM_ACTORS*TILE_W-1:0] actor_tile,
  actor_tile_committer_if.master       ram,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_ACTORS*ADDR_W-1:0] actor_loc,
  output logic [NUM_ACTORS-1:0]        collision,
  output logic [NUM_ACTORS-1:0]        loc_err
);
  localparam int unsigned IDX_W  = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1;
  localparam int unsigned WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_DRAW_RD, S_DRAW_WAIT, S_DRAW_WR, S_FINISH
  } state_t;

  state_t              state_q, state_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [WAIT_W-1:0]   wait_q, wait_n;
  logic [NUM_ACTORS-1:0] moved_q, moved_in, err_in, coll_n;
  logic                first_pending_q;
  logic [ADDR_W-1:0]   cur_q   [NUM_ACTORS];
  logic [ADDR_W-1:0]   old_q   [NUM_ACTORS];
  logic [ADDR_W-1:0]   nxt_q   [NUM_ACTORS];
  logic [ADDR_W-1:0]   next_in [NUM_ACTORS];
  logic [ADDR_W-1:0]   nsel    [NUM_ACTORS];
  logic [TILE_W-1:0]   under_q [NUM_ACTORS];
  logic [TILE_W-1:0]   tile_in [NUM_ACTORS];
  logic [ADDR_W-1:0]   addr_n;
  logic [TILE_W-1:0]   wdata_n;
  logic                we_n;
  logic [IDX_W:0]      dn, up;

  // Highest moved index strictly below 'from'; MSB flags a hit.
  function automatic logic [IDX_W:0] find_down(input logic [NUM_ACTORS-1:0] m, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_ACTORS); i++)
      if (m[i] && (i < from)) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  // Lowest moved index strictly above 'from'; MSB flags a hit.
  function automatic logic [IDX_W:0] find_up(input logic [NUM_ACTORS-1:0] m, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = int'(NUM_ACTORS) - 1; i >= 0; i--)
      if (m[i] && (i > from)) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  // Unpack request buses; classify each actor as moved or out of range.
  always_comb begin
    for (int i = 0; i < int'(NUM_ACTORS); i++) begin
      next_in[i]  = next_loc[i*ADDR_W +: ADDR_W];
      tile_in[i]  = actor_tile[i*TILE_W +: TILE_W];
      err_in[i]   = ((ADDR_W+1)'(next_in[i]) >= (ADDR_W+1)'(NUM_TILES));
      moved_in[i] = !err_in[i] && ((next_in[i] != cur_q[i]) || first_pending_q);
      nsel[i]     = (state_q == S_IDLE) ? next_in[i] : nxt_q[i];
    end
  end

  // Collision against PacMan's new tile, including head-on swaps.
  always_comb begin
    coll_n = '0;
    for (int i = 1; i < int'(NUM_ACTORS); i++)
      coll_n[i] = (cur_q[i] == cur_q[0]) ||
                  ((old_q[i] == cur_q[0]) && (old_q[0] == cur_q[i]));
    coll_n[0] = |coll_n;
  end

  // Next-state logic plus the RAM port values for the upcoming state.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    wait_n  = wait_q;
    dn      = '0;
    up      = '0;
    case (state_q)
      S_IDLE: if (start) begin
        dn = find_down(moved_in, int'(NUM_ACTORS));
        up = find_up(moved_in, -1);
        if (!first_pending_q && dn[IDX_W]) begin
          state_n = S_ERASE;
          idx_n   = dn[IDX_W-1:0];
        end else if (up[IDX_W]) begin
          state_n = S_DRAW_RD;
          idx_n   = up[IDX_W-1:0];
        end else begin
          state_n = S_FINISH;
        end
      end
      S_ERASE: begin
        dn = find_down(moved_q, int'(idx_q));
        up = find_up(moved_q, -1);
        if (dn[IDX_W]) begin
          idx_n = dn[IDX_W-1:0];
        end else begin
          state_n = S_DRAW_RD;
          idx_n   = up[IDX_W-1:0];
        end
      end
      S_DRAW_RD: begin
        if (RD_LAT > 1) begin
          state_n = S_DRAW_WAIT;
          wait_n  = WAIT_W'(RD_LAT - 2);
        end else begin
          state_n = S_DRAW_WR;
        end
      end
      S_DRAW_WAIT: begin
        if (wait_q == '0) state_n = S_DRAW_WR;
        else              wait_n  = wait_q - WAIT_W'(1);
      end
      S_DRAW_WR: begin
        up = find_up(moved_q, int'(idx_q));
        if (up[IDX_W]) begin
          state_n = S_DRAW_RD;
          idx_n   = up[IDX_W-1:0];
        end else begin
          state_n = S_FINISH;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    we_n    = (state_n == S_ERASE) || (state_n == S_DRAW_WR);
    addr_n  = '0;
    wdata_n = '0;
    case (state_n)
      S_ERASE: begin
        addr_n  = cur_q[idx_n];
        wdata_n = under_q[idx_n];
      end
      S_DRAW_RD, S_DRAW_WAIT: addr_n = nsel[idx_n];
      S_DRAW_WR: begin
        addr_n  = nsel[idx_n];
        wdata_n = tile_in[idx_n];
      end
      default: ;
    endcase
  end

  // State, index and read-latency counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      wait_q  <= wait_n;
    end
  end

  // Actor bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_ACTORS); i++) begin
        cur_q[i]   <= INIT_LOCS[i*ADDR_W +: ADDR_W];
        old_q[i]   <= INIT_LOCS[i*ADDR_W +: ADDR_W];
        nxt_q[i]   <= INIT_LOCS[i*ADDR_W +: ADDR_W];
        under_q[i] <= BG_TILE;
      end
      moved_q         <= '0;
      first_pending_q <= 1'b1;
      ram.ram_addr    <= '0;
      ram.ram_we      <= 1'b0;
      ram.ram_wdata   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      collision       <= '0;
      loc_err         <= '0;
    end else begin
      ram.ram_addr  <= addr_n;
      ram.ram_we    <= we_n;
      ram.ram_wdata <= wdata_n;
      busy          <= (state_n != S_IDLE);
      done          <= (state_q == S_FINISH);
      if (state_q == S_IDLE && start) begin
        moved_q <= moved_in;
        loc_err <= err_in;
        for (int i = 0; i < int'(NUM_ACTORS); i++) begin
          nxt_q[i] <= next_in[i];
          old_q[i] <= cur_q[i];
        end
      end
      if (state_q == S_DRAW_WR) begin
        under_q[idx_q] <= ram.ram_rdata;
        cur_q[idx_q]   <= nxt_q[idx_q];
      end
      if (state_q == S_FINISH) begin
        collision       <= coll_n;
        first_pending_q <= 1'b0;
      end
    end
  end

  // Committed locations exposed as a packed bus.
  for (genvar g = 0; g < int'(NUM_ACTORS); g++) begin : g_loc
    assign actor_loc[g*ADDR_W +: ADDR_W] = cur_q[g];
  end
endmodule

// File: tb/tb_actor_tile_committer.sv
// Directed bench for actor_tile_committer with a 1-cycle-latency board RAM model.
module tb_actor_tile_committer;
  localparam logic [49:0] INIT = {10'd50, 10'd40, 10'd30, 10'd20, 10'd10};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [49:0] next_loc;
  logic [19:0] actor_tile;
  logic        busy, done;
  logic [49:0] actor_loc;
  logic [4:0]  collision, loc_err;

  int n_vec = 0;
  int n_err = 0;
  int wr_total = 0;
  int addr_bad = 0;
  int bc, w0;

  logic [3:0] mem [1024];

  actor_tile_committer_if #(.ADDR_W(10), .TILE_W(4)) ram_bus ();

  actor_tile_committer #(
    .NUM_ACTORS(5), .ADDR_W(10), .NUM_TILES(768), .TILE_W(4), .RD_LAT(1),
    .BG_TILE(4'h0), .INIT_LOCS(INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .next_loc(next_loc),
    .actor_tile(actor_tile), .ram(ram_bus.master), .busy(busy), .done(done),
    .actor_loc(actor_loc), .collision(collision), .loc_err(loc_err)
  );

  always #5 clk = ~clk;

  // Board RAM: registered read, synchronous write.
  always @(posedge clk) begin
    ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
    if (ram_bus.ram_we) begin
      mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
      wr_total <= wr_total + 1;
    end
    if (ram_bus.ram_addr >= 10'd768) addr_bad <= addr_bad + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [49:0] nl, output int cyc);
    @(negedge clk);
    next_loc = nl;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    next_loc   = INIT;
    actor_tile = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    for (int a = 0; a < 1024; a++) mem[a] = 4'h0;
    repeat (2) @(negedge clk);

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(ram_bus.ram_we), 64'd0);
    check("rst_addr", 64'(ram_bus.ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_bus.ram_wdata), 64'd0);
    check("rst_coll", 64'(collision), 64'd0);
    check("rst_lerr", 64'(loc_err), 64'd0);
    check("rst_loc", 64'(actor_loc), 64'(INIT));
    reset_n = 1'b1;

    // First commit: draw all five, no erase.
    w0 = wr_total;
    commit(INIT, bc);
    check("t1_busy", 64'(bc), 64'd11);
    check("t1_done", 64'(done), 64'd1);
    check("t1_writes", 64'(wr_total - w0), 64'd5);
    check("t1_board", 64'({mem[50], mem[40], mem[30], mem[20], mem[10]}), 64'h54321);
    check("t1_coll", 64'(collision), 64'd0);
    @(negedge clk);
    check("t1_done_clr", 64'(done), 64'd0);

    // PacMan 10 -> 11.
    w0 = wr_total;
    commit({10'd50, 10'd40, 10'd30, 10'd20, 10'd11}, bc);
    check("t2_busy", 64'(bc), 64'd4);
    check("t2_writes", 64'(wr_total - w0), 64'd2);
    check("t2_board", 64'({mem[11], mem[10]}), 64'h10);
    check("t2_loc0", 64'(actor_loc[9:0]), 64'd11);

    // Ghost 1 onto PacMan, then away again.
    commit({10'd50, 10'd40, 10'd30, 10'd11, 10'd11}, bc);
    check("t3_busy", 64'(bc), 64'd4);
    check("t3_board", 64'({mem[11], mem[20]}), 64'h20);
    check("t3_coll", 64'(collision), 64'b00011);
    commit({10'd50, 10'd40, 10'd30, 10'd20, 10'd11}, bc);
    check("t3_leave_board", 64'({mem[11], mem[20]}), 64'h12);
    check("t3_leave_coll", 64'(collision), 64'd0);

    // Swap: ghost 1 to 12, then exchange with PacMan.
    commit({10'd50, 10'd40, 10'd30, 10'd12, 10'd11}, bc);
    check("t4_prep_board", 64'({mem[12], mem[20]}), 64'h20);
    commit({10'd50, 10'd40, 10'd30, 10'd11, 10'd12}, bc);
    check("t4_busy", 64'(bc), 64'd7);
    check("t4_board", 64'({mem[11], mem[12]}), 64'h21);
    check("t4_coll", 64'(collision), 64'b00011);

    // Out-of-range request for actor 2.
    w0 = wr_total;
    commit({10'd50, 10'd40, 10'd800, 10'd11, 10'd12}, bc);
    check("t5_busy", 64'(bc), 64'd1);
    check("t5_done", 64'(done), 64'd1);
    check("t5_lerr", 64'(loc_err), 64'b00100);
    check("t5_loc2", 64'(actor_loc[29:20]), 64'd30);
    check("t5_writes", 64'(wr_total - w0), 64'd0);
    check("t5_coll", 64'(collision), 64'd0);

    // Start held while busy with a different request: ignored.
    @(negedge clk);
    next_loc = {10'd50, 10'd40, 10'd30, 10'd11, 10'd13};
    start    = 1'b1;
    @(negedge clk);
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      if (bc == 1) next_loc = {10'd50, 10'd40, 10'd30, 10'd11, 10'd14};
      if (bc == 2) start = 1'b0;
      @(negedge clk);
    end
    check("t6_busy", 64'(bc), 64'd4);
    check("t6_lerr", 64'(loc_err), 64'd0);
    check("t6_loc0", 64'(actor_loc[9:0]), 64'd13);
    check("t6_board", 64'({mem[12], mem[13], mem[14]}), 64'h010);
    @(negedge clk);
    check("t6_idle", 64'(busy), 64'd0);

    // Reset asserted during an erase write.
    next_loc = {10'd50, 10'd40, 10'd30, 10'd11, 10'd14};
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_erase_we", 64'(ram_bus.ram_we), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_we", 64'(ram_bus.ram_we), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_loc", 64'(actor_loc), 64'(INIT));
    @(negedge clk);
    reset_n = 1'b1;

    // Commit after reset redraws everything.
    w0 = wr_total;
    commit(INIT, bc);
    check("t6_redraw_busy", 64'(bc), 64'd11);
    check("t6_redraw_writes", 64'(wr_total - w0), 64'd5);
    check("t6_redraw_board", 64'({mem[50], mem[40], mem[30], mem[20], mem[10]}), 64'h54321);
    check("addr_range", 64'(addr_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
